// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises single register read/write commands
// onto MDC/MDIO and returns read data with a turnaround-error flag.
module mdio_master #(
    parameter int unsigned CLK_DIV  = 25,
    parameter bit          PREAMBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int unsigned     DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax    = DivW'(CLK_DIV - 1);
    localparam logic [6:0]      FrameBits = PREAMBLE ? 7'd64 : 7'd32;

    typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

    state_e          state;
    logic [63:0]     shreg;
    logic [6:0]      bit_left;
    logic [DivW-1:0] div_cnt;
    logic            is_read;
    logic [63:0]     frame_raw;
    logic [63:0]     frame_load;

    // Bits are counted down to the end of the frame, so TA/data positions are
    // the same with or without the preamble: TA = 18,17 remaining, data = 16..1.
    always_comb begin
        frame_raw = {32'hFFFF_FFFF, 2'b01,
                     cmd_write ? 2'b01 : 2'b10,
                     cmd_phy_addr, cmd_reg_addr,
                     cmd_write ? 2'b10 : 2'b11,
                     cmd_write ? cmd_wdata : 16'h0000};
        frame_load = PREAMBLE ? frame_raw : {frame_raw[31:0], 32'h0000_0000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            shreg     <= '0;
            bit_left  <= '0;
            div_cnt   <= '0;
            is_read   <= 1'b0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        shreg     <= frame_load;
                        bit_left  <= FrameBits;
                        div_cnt   <= '0;
                        is_read   <= !cmd_write;
                        mdc       <= 1'b0;
                        mdio_o    <= frame_load[63];
                        mdio_oe   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StShift;
                    end
                end

                StShift: begin
                    if (div_cnt != DivMax) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (!mdc) begin
                        div_cnt <= '0;
                        mdc     <= 1'b1;
                        if (is_read) begin
                            if (bit_left == 7'd17 && mdio_i) begin
                                rsp_err <= 1'b1;
                            end
                            if (bit_left <= 7'd16) begin
                                rsp_rdata <= {rsp_rdata[14:0], mdio_i};
                            end
                        end
                    end else begin
                        div_cnt <= '0;
                        mdc     <= 1'b0;
                        if (bit_left == 7'd1) begin
                            mdio_o    <= 1'b1;
                            mdio_oe   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= StResp;
                        end else begin
                            bit_left <= bit_left - 1'b1;
                            shreg    <= {shreg[62:0], 1'b0};
                            mdio_o   <= shreg[62];
                            // Release the bus from the first TA bit of a read onwards.
                            mdio_oe  <= !is_read || (bit_left > 7'd19);
                        end
                    end
                end

                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed and random commands against a frame-level model
// of the MDIO protocol and a simple PHY responder.
module tb_mdio_master;

    localparam int D1 = 25;
    localparam int N1 = 64;
    localparam int D2 = 2;
    localparam int N2 = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phy_addr = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        mdio_i = 1'b1;

    logic        cmd_ready1, rsp_valid1, rsp_err1, busy1, mdc1, mdio_o1, mdio_oe1;
    logic        cmd_ready2, rsp_valid2, rsp_err2, busy2, mdc2, mdio_o2, mdio_oe2;
    logic [15:0] rsp_rdata1, rsp_rdata2;
    logic        cv1, cv2;

    assign cv1 = cmd_valid & ~sel;
    assign cv2 = cmd_valid & sel;

    mdio_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .busy(busy1), .mdc(mdc1), .mdio_o(mdio_o1),
        .mdio_oe(mdio_oe1), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(D2), .PREAMBLE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cv2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
        .rsp_err(rsp_err2), .busy(busy2), .mdc(mdc2), .mdio_o(mdio_o2),
        .mdio_oe(mdio_oe2), .mdio_i(mdio_i)
    );

    logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_busy, m_mdc, m_mdio_o, m_mdio_oe;
    logic [15:0] m_rsp_rdata;
    assign m_cmd_ready = sel ? cmd_ready2 : cmd_ready1;
    assign m_rsp_valid = sel ? rsp_valid2 : rsp_valid1;
    assign m_rsp_err   = sel ? rsp_err2   : rsp_err1;
    assign m_rsp_rdata = sel ? rsp_rdata2 : rsp_rdata1;
    assign m_busy      = sel ? busy2      : busy1;
    assign m_mdc       = sel ? mdc2       : mdc1;
    assign m_mdio_o    = sel ? mdio_o2    : mdio_o1;
    assign m_mdio_oe   = sel ? mdio_oe2   : mdio_oe1;

    int n_checks = 0;
    int n_fail = 0;

    // Model state for the command in flight
    int          nb = N1;
    int          dv = D1;
    logic [63:0] exp_bits, exp_oe, phy_drv;
    logic [15:0] exp_rdata;
    logic        exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit i (MSB first, i = 0 is the first bit on the wire) and what the PHY drives.
    task automatic model_cmd(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic [15:0] pd, input bit phy_ok);
        logic [63:0] f;
        f = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, (wr ? wd : 16'h0000)};
        exp_bits = '0;
        exp_oe   = '0;
        phy_drv  = '1;
        for (int i = 0; i < nb; i++) begin
            exp_bits[i] = f[nb-1-i];
            exp_oe[i]   = wr || (i < nb - 18);
        end
        if (!wr && phy_ok) begin
            phy_drv[nb-17] = 1'b0;
            for (int j = 0; j < 16; j++) phy_drv[nb-16+j] = pd[15-j];
        end
        exp_rdata    = wr ? 16'h0000 : (phy_ok ? pd : 16'hFFFF);
        exp_err      = !wr && !phy_ok;
        cmd_write    = wr;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
    endtask

    // Returns at #1 after the handshake edge, then scrambles the command inputs.
    task automatic handshake(input string tag);
        @(negedge clk);
        check({tag, " cmd_ready idle"}, m_cmd_ready, 1);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_write    = ~cmd_write;
        cmd_wdata    = 16'($urandom);
        cmd_phy_addr = 5'($urandom);
        cmd_reg_addr = 5'($urandom);
    endtask

    // Called at #1 after the handshake edge; k counts edges since the handshake.
    task automatic watch(input string tag);
        int          k = 0;
        int          nrise = 0;
        int          mdc_bad = 0;
        int          k_rsp = -1;
        logic        prev = 1'b0;
        logic        exp_mdc;
        logic [63:0] got = '0;
        logic [63:0] got_oe = '0;
        bit          done = 1'b0;
        while (!done && k <= 2*nb*dv + 40) begin
            if (m_rsp_valid === 1'b1) begin
                done  = 1'b1;
                k_rsp = k;
            end else begin
                exp_mdc = (k < 2*nb*dv) ? (((k / dv) % 2) == 1) : 1'b0;
                if (m_mdc !== exp_mdc) mdc_bad++;
                if (m_mdc === 1'b1 && prev === 1'b0 && nrise < 64) begin
                    got[nrise]    = m_mdio_o;
                    got_oe[nrise] = m_mdio_oe;
                    nrise++;
                end
                prev   = m_mdc;
                mdio_i = (nrise < 64) ? phy_drv[nrise] : 1'b1;
                @(posedge clk);
                #1;
                k++;
            end
        end
        mdio_i = 1'b1;
        check({tag, " rsp_valid cycle"}, 64'(k_rsp + 1), 64'(2*nb*dv + 1));
        check({tag, " mdc timing errors"}, 64'(mdc_bad), 0);
        check({tag, " mdc rising count"}, 64'(nrise), 64'(nb));
        check({tag, " frame bits"}, got & exp_oe, exp_bits & exp_oe);
        check({tag, " mdio_oe per bit"}, got_oe, exp_oe);
        check({tag, " rsp_rdata"}, m_rsp_rdata, exp_rdata);
        check({tag, " rsp_err"}, m_rsp_err, exp_err);
        check({tag, " resp pins mdc/o/oe/ready/busy"},
              {m_mdc, m_mdio_o, m_mdio_oe, m_cmd_ready, m_busy}, 5'b01001);
    endtask

    task automatic finish_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " after rsp valid/ready/busy"}, {m_rsp_valid, m_cmd_ready, m_busy}, 3'b010);
    endtask

    task automatic run(input string tag, input bit wr, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd,
                       input logic [15:0] pd, input bit phy_ok);
        model_cmd(wr, pa, ra, wd, pd, phy_ok);
        handshake(tag);
        watch(tag);
        finish_rsp(tag);
    endtask

    initial begin
        logic [15:0] saved_data;
        logic        saved_err;
        int          bad;

        #1 rst_n = 1'b0;
        #1;
        check("reset dut", {mdc1, mdio_o1, mdio_oe1, cmd_ready1, rsp_valid1, rsp_rdata1,
                            rsp_err1, busy1}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        check("reset dut2", {mdc2, mdio_o2, mdio_oe2, cmd_ready2, rsp_valid2, rsp_rdata2,
                             rsp_err2, busy2}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run("t1 write", 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b1);
        run("t2 read", 1'b0, 5'h01, 5'h02, 16'h0000, 16'h0022, 1'b1);
        run("t3 ta error", 1'b0, 5'h01, 5'h02, 16'h0000, 16'h0000, 1'b0);

        // Backpressure with a queued second command
        model_cmd(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom) | 16'h8001, 1'b1);
        handshake("t4a");
        watch("t4a");
        saved_data = m_rsp_rdata;
        saved_err  = m_rsp_err;
        model_cmd(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b1);
        cmd_valid = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if ({m_rsp_valid, m_cmd_ready, m_busy, m_mdc, m_rsp_rdata, m_rsp_err} !==
                {1'b1, 1'b0, 1'b1, 1'b0, saved_data, saved_err}) bad++;
        end
        check("t4 stable under backpressure", 64'(bad), 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("t4 rsp edge valid/busy/ready", {m_rsp_valid, m_busy, m_cmd_ready}, 3'b001);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t4 second start busy/ready/mdc/oe", {m_busy, m_cmd_ready, m_mdc, m_mdio_oe},
              4'b1001);
        watch("t4b");
        finish_rsp("t4b");

        // Reset during the high phase of bit 40
        model_cmd(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b1);
        handshake("t5");
        repeat (2*40*D1 + D1 + 3) @(posedge clk);
        #1;
        check("t5 mdc high before reset", m_mdc, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async reset pins", {m_mdc, m_mdio_o, m_mdio_oe, m_cmd_ready, m_busy, m_rsp_valid},
              6'b010100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("t5 write after reset", 1'b1, 5'h1F, 5'h1B, 16'hA5C3, 16'h0, 1'b1);

        for (int i = 0; i < 2; i++) begin
            bit wr;
            wr = 1'($urandom);
            run("rand dut", wr, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 3) != 0));
        end

        // No preamble, CLK_DIV = 2
        sel = 1'b1;
        nb  = N2;
        dv  = D2;
        run("t6 write", 1'b1, 5'h03, 5'h04, 16'hBEEF, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit wr;
            wr = 1'($urandom);
            run("rand dut2", wr, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
